// File: rtl/mc_ctrl_pkg.sv
// Purpose : shared encodings for the multicycle MIPS controller and the ALU it drives
//           (state enum, opcode/funct constants, ALU op codes, mux select codes).
// Latency : n/a (package).  Backpressure: n/a.
// Macro   : MC_CTRL_BNE_EN (consumed by mc_controller) enables bne decode.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11
   } state_t;

   // instr[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // instr[5:0] for R-type
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;
   localparam logic [5:0] FUNCT_SLL = 6'b000000;
   localparam logic [5:0] FUNCT_SRL = 6'b000010;

   // ALU operation codes, identical to the ALU's own decode
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;
   localparam logic [2:0] ALU_SLL = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;

   // ALU operand B select
   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // next-PC select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Purpose : maps an R-type funct field to the 3-bit ALU op and flags unsupported functs.
// Latency : combinational, 0 cycles.
// Backpressure: none (pure decode).
// Ports   : funct (in, 6) ; alu_control (out, 3, ADD when illegal) ; funct_legal (out, 1)
module alu_decoder
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_control,
   output logic       funct_legal
);

   always_comb begin
      alu_control = ALU_ADD;
      funct_legal = 1'b1;
      case (funct)
         FUNCT_ADD: alu_control = ALU_ADD;
         FUNCT_SUB: alu_control = ALU_SUB;
         FUNCT_AND: alu_control = ALU_AND;
         FUNCT_OR:  alu_control = ALU_OR;
         FUNCT_SLT: alu_control = ALU_SLT;
         FUNCT_SLL: alu_control = ALU_SLL;
         FUNCT_SRL: alu_control = ALU_SRL;
         default:   funct_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Purpose : multicycle MIPS control FSM, one instruction at a time (fetch/decode/exec/mem/wb).
// Latency : beq/j 3, R/addi/sw 4, lw 5 cycles; +1 per cycle memory is not ready.
// Backpressure: FETCH, MEMRD and MEMWR hold (outputs steady) until mem_ready.
// Macro   : MC_CTRL_BNE_EN -> opcode 000101 (bne) is legal and branches on ~zero.
// Ports   : clk, rst_n (async, active-low); opcode/funct from IR; zero from ALU;
//           mem_ready from memory; outputs are the datapath enables and mux selects,
//           alu_control to the shared ALU, illegal_op pulses in DECODE on bad encodings.
module mc_controller
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       iord,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_control,
   output logic [1:0] pc_src,
   output logic       illegal_op
);

   state_t     state;
   state_t     state_nxt;
   logic [2:0] funct_alu;
   logic       funct_legal;

   alu_decoder u_alu_decoder (
      .funct       (funct),
      .alu_control (funct_alu),
      .funct_legal (funct_legal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= state_nxt;
   end

`ifdef MC_CTRL_BNE_EN
   // BRANCH needs to know which sense of zero to use; capture it while the
   // opcode is being dispatched rather than re-reading the IR later.
   logic branch_ne;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               branch_ne <= 1'b0;
      else if (state == DECODE) branch_ne <= (opcode == OP_BNE);
   end
`endif

   always_comb begin
      state_nxt   = state;
      pc_en       = 1'b0;
      iord        = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = SRCB_REG;
      alu_control = ALU_ADD;
      pc_src      = PCSRC_ALU;
      illegal_op  = 1'b0;

      case (state)
         FETCH: begin
            // PC+4 is computed every cycle but only committed with the IR load.
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_en     = mem_ready;
            if (mem_ready) state_nxt = DECODE;
         end
         DECODE: begin
            // Speculatively form the branch target into ALUOut.
            alu_src_b = SRCB_IMM_SH2;
            case (opcode)
               OP_RTYPE: begin
                  if (funct_legal) state_nxt = EXECUTE;
                  else begin
                     illegal_op = 1'b1;
                     state_nxt  = FETCH;
                  end
               end
               OP_LW, OP_SW: state_nxt = MEMADR;
               OP_BEQ:       state_nxt = BRANCH;
`ifdef MC_CTRL_BNE_EN
               OP_BNE:       state_nxt = BRANCH;
`else
               OP_BNE: begin
                  illegal_op = 1'b1;
                  state_nxt  = FETCH;
               end
`endif
               OP_ADDI:      state_nxt = ADDIEX;
               OP_J:         state_nxt = JUMP;
               default: begin
                  illegal_op = 1'b1;
                  state_nxt  = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_nxt = (opcode == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            iord = 1'b1;
            if (mem_ready) state_nxt = MEMWB;
         end
         MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            state_nxt  = FETCH;
         end
         MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) state_nxt = FETCH;
         end
         EXECUTE: begin
            alu_src_a   = 1'b1;
            alu_control = funct_alu;
            state_nxt   = ALUWB;
         end
         ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            state_nxt = FETCH;
         end
         BRANCH: begin
            alu_src_a   = 1'b1;
            alu_control = ALU_SUB;
            pc_src      = PCSRC_ALUOUT;
`ifdef MC_CTRL_BNE_EN
            pc_en       = branch_ne ? ~zero : zero;
`else
            pc_en       = zero;
`endif
            state_nxt   = FETCH;
         end
         ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_nxt = ADDIWB;
         end
         ADDIWB: begin
            reg_write = 1'b1;
            state_nxt = FETCH;
         end
         JUMP: begin
            pc_src    = PCSRC_JUMP;
            pc_en     = 1'b1;
            state_nxt = FETCH;
         end
         default: state_nxt = FETCH;
      endcase
   end

endmodule

// File: tb/tb_mc_controller.sv
// Purpose : scoreboard bench for mc_controller; every cycle the stimulus pushes the
//           expected control vector, a negedge monitor pops and compares it.
// Build with and without MC_CTRL_BNE_EN; the bne expectations follow the macro.
module tb_mc_controller;

   typedef struct packed {
      logic       pc_en;
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_control;
      logic [1:0] pc_src;
      logic       illegal_op;
   } ctl_t;

   typedef enum int {
      P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
      P_EXEC, P_ALUWB, P_BRANCH, P_ADDIEX, P_ADDIWB, P_JUMP
   } ph_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_control;
   logic [1:0] pc_src;
   logic       illegal_op;

   ctl_t       act;
   ctl_t       exp_q[$];
   string      name_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;

   // current instruction context used by step()
   logic [5:0] cur_op;
   logic [5:0] cur_fn;
   logic [2:0] cur_alu;
   logic       cur_zero;
   logic       cur_bne;

   always #5 clk = ~clk;

   mc_controller dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (opcode),
      .funct       (funct),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .pc_en       (pc_en),
      .iord        (iord),
      .mem_write   (mem_write),
      .ir_write    (ir_write),
      .reg_dst     (reg_dst),
      .mem_to_reg  (mem_to_reg),
      .reg_write   (reg_write),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .alu_control (alu_control),
      .pc_src      (pc_src),
      .illegal_op  (illegal_op)
   );

   assign act = '{pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, alu_control, pc_src, illegal_op};

   // Expected Moore outputs per phase, straight from the state table.
   function automatic ctl_t model(input ph_t ph, input logic mr, input logic z,
                                  input logic [2:0] alu, input logic ill, input logic bne);
      ctl_t c;
      c = '0;
      c.alu_control = 3'b010;
      case (ph)
         P_FETCH:  begin c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_en = mr; end
         P_DECODE: begin c.alu_src_b = 2'b11; c.illegal_op = ill; end
         P_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         P_MEMRD:  c.iord = 1'b1;
         P_MEMWB:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
         P_MEMWR:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
         P_EXEC:   begin c.alu_src_a = 1'b1; c.alu_control = alu; end
         P_ALUWB:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
         P_BRANCH: begin
            c.alu_src_a = 1'b1; c.alu_control = 3'b110; c.pc_src = 2'b01;
            c.pc_en = bne ? ~z : z;
         end
         P_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         P_ADDIWB: c.reg_write = 1'b1;
         P_JUMP:   begin c.pc_src = 2'b10; c.pc_en = 1'b1; end
         default:  ;
      endcase
      return c;
   endfunction

   // One clock: drive inputs just after the edge and queue what the DUT must show.
   task automatic step(input string nm, input ph_t ph, input logic mr,
                       input logic ill, input logic rst);
      @(posedge clk);
      #1;
      rst_n     = rst;
      mem_ready = mr;
      opcode    = cur_op;
      funct     = cur_fn;
      zero      = cur_zero;
      exp_q.push_back(model(ph, mr, cur_zero, cur_alu, ill, cur_bne));
      name_q.push_back(nm);
   endtask

   task automatic begin_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                              input logic [2:0] alu, input logic z, input logic bne,
                              input logic ill);
      cur_op = op; cur_fn = fn; cur_alu = alu; cur_zero = z; cur_bne = bne;
      step({nm, "_fetch"},  P_FETCH,  1'b1, 1'b0, 1'b1);
      step({nm, "_decode"}, P_DECODE, 1'b1, ill,  1'b1);
   endtask

   task automatic do_lw(input string nm, input int waits);
      begin_instr(nm, 6'b100011, 6'b000000, 3'b010, 1'b0, 1'b0, 1'b0);
      step({nm, "_memadr"}, P_MEMADR, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < waits; i++) step({nm, "_memrd_wait"}, P_MEMRD, 1'b0, 1'b0, 1'b1);
      step({nm, "_memrd"}, P_MEMRD, 1'b1, 1'b0, 1'b1);
      step({nm, "_memwb"}, P_MEMWB, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic do_sw(input string nm, input int waits);
      begin_instr(nm, 6'b101011, 6'b000000, 3'b010, 1'b0, 1'b0, 1'b0);
      step({nm, "_memadr"}, P_MEMADR, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < waits; i++) step({nm, "_memwr_wait"}, P_MEMWR, 1'b0, 1'b0, 1'b1);
      step({nm, "_memwr"}, P_MEMWR, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic do_rtype(input string nm, input logic [5:0] fn, input logic [2:0] alu);
      begin_instr(nm, 6'b000000, fn, alu, 1'b0, 1'b0, 1'b0);
      step({nm, "_exec"},  P_EXEC,  1'b1, 1'b0, 1'b1);
      step({nm, "_aluwb"}, P_ALUWB, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic do_branch(input string nm, input logic [5:0] op, input logic z,
                            input logic bne);
      begin_instr(nm, op, 6'b000000, 3'b010, z, bne, 1'b0);
      step({nm, "_branch"}, P_BRANCH, 1'b1, 1'b0, 1'b1);
   endtask

   // Monitor: compare whatever the DUT presents against the oldest expectation.
   initial begin
      ctl_t  e;
      string n;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            n_checks++;
            if (act !== e) begin
               n_fail++;
               $display("FAIL %s: actual %b required %b", n, act, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, %0d checks %0d failures", n_checks, n_fail);
      $fatal(1, "timeout");
   end

   initial begin
      logic [5:0] r_fn  [7];
      logic [2:0] r_alu [7];
      r_fn[0] = 6'b100000; r_alu[0] = 3'b010;   // add
      r_fn[1] = 6'b100010; r_alu[1] = 3'b110;   // sub
      r_fn[2] = 6'b100100; r_alu[2] = 3'b000;   // and
      r_fn[3] = 6'b100101; r_alu[3] = 3'b001;   // or
      r_fn[4] = 6'b101010; r_alu[4] = 3'b111;   // slt
      r_fn[5] = 6'b000000; r_alu[5] = 3'b100;   // sll
      r_fn[6] = 6'b000010; r_alu[6] = 3'b101;   // srl

      rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
      cur_op = '0; cur_fn = '0; cur_alu = 3'b010; cur_zero = 1'b0; cur_bne = 1'b0;

      // reset: FETCH decode, ir_write/pc_en follow mem_ready
      step("rst_idle",   P_FETCH, 1'b0, 1'b0, 1'b0);
      step("rst_mready", P_FETCH, 1'b1, 1'b0, 1'b0);

      do_lw("lw", 0);                                 // released inside first fetch
      step("fetch_stall", P_FETCH, 1'b0, 1'b0, 1'b1);
      do_lw("lw_wait3", 3);
      do_sw("sw", 0);
      do_sw("sw_wait1", 1);

      for (int i = 0; i < 7; i++) do_rtype($sformatf("r_fn%b", r_fn[i]), r_fn[i], r_alu[i]);

      begin_instr("addi", 6'b001000, 6'b000000, 3'b010, 1'b0, 1'b0, 1'b0);
      step("addi_ex", P_ADDIEX, 1'b1, 1'b0, 1'b1);
      step("addi_wb", P_ADDIWB, 1'b1, 1'b0, 1'b1);

      do_branch("beq_taken",  6'b000100, 1'b1, 1'b0);
      do_branch("beq_not",    6'b000100, 1'b0, 1'b0);

      begin_instr("j", 6'b000010, 6'b000000, 3'b010, 1'b0, 1'b0, 1'b0);
      step("j_jump", P_JUMP, 1'b1, 1'b0, 1'b1);

      begin_instr("ill_op",    6'b111111, 6'b000000, 3'b010, 1'b0, 1'b0, 1'b1);
      begin_instr("ill_funct", 6'b000000, 6'b000011, 3'b010, 1'b0, 1'b0, 1'b1);

`ifdef MC_CTRL_BNE_EN
      do_branch("bne_taken", 6'b000101, 1'b0, 1'b1);
      do_branch("bne_not",   6'b000101, 1'b1, 1'b1);
`else
      begin_instr("bne_ill", 6'b000101, 6'b000000, 3'b010, 1'b0, 1'b0, 1'b1);
`endif
      do_branch("beq_after_bne", 6'b000100, 1'b1, 1'b0);

      // async reset while a store is waiting on memory
      begin_instr("sw_rst", 6'b101011, 6'b000000, 3'b010, 1'b0, 1'b0, 1'b0);
      step("sw_rst_memadr", P_MEMADR, 1'b1, 1'b0, 1'b1);
      step("sw_rst_memwr",  P_MEMWR,  1'b0, 1'b0, 1'b1);
      step("rst_in_memwr",  P_FETCH,  1'b0, 1'b0, 1'b0);
      step("rst_hold",      P_FETCH,  1'b0, 1'b0, 1'b0);
      begin_instr("addi_post", 6'b001000, 6'b000000, 3'b010, 1'b0, 1'b0, 1'b0);
      step("addi_post_ex", P_ADDIEX, 1'b1, 1'b0, 1'b1);
      step("addi_post_wb", P_ADDIWB, 1'b1, 1'b0, 1'b1);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: actual %0d pending required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
